weyl_sched: RTL and testbench
=============================

WEYL_SCHED -- requirements
Module: weyl_sched

Interface
REQ-001 Parameter BITSTREAM, default 64: stream length in beats, power of two.
REQ-002 Parameter BASE, default 61: Weyl start offset, 0..BITSTREAM-1.
REQ-003 Parameter STRIDE, default 17: Weyl stride, odd, so it is coprime with BITSTREAM.
REQ-004 Parameter NREQ, default 4: number of requesters, 2..16.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 flush  input  1  synchronous abort of the stream in progress.
REQ-008 req_valid  input  NREQ  per-requester request.
REQ-009 req_quota  input  NREQ x clog2(BITSTREAM)  per-requester quota (number of ones in the stream).
REQ-010 req_ready  output  NREQ  one-hot grant; a request is accepted when req_valid[n] and req_ready[n] are both high.
REQ-011 out_valid  output  1  stream beat valid.
REQ-012 out_ready  input  1  downstream accepts the beat.
REQ-013 out_bit  output  1  stream bit.
REQ-014 out_id  output  clog2(NREQ)  owner of the current stream.
REQ-015 out_last  output  1  final beat of the stream.
REQ-016 busy  output  1  high in STREAM state.

Function
REQ-017 FSM has two states. IDLE moves to STREAM when any req_valid is high. STREAM moves to IDLE when the last beat is handshaken or flush is high.
REQ-018 In IDLE, req_ready is combinationally one-hot on the round-robin winner among asserted req_valid; it is all-zero when no request is asserted and all-zero in STREAM.
REQ-019 Round-robin: search starts at pointer rr_ptr. On each grant g, rr_ptr becomes (g+1) mod NREQ.
REQ-020 On grant, the block latches pattern vector P[BITSTREAM-1:0] and the granted index into out_id.
REQ-021 P bit at index (BASE + i*STRIDE) mod BITSTREAM equals 1 exactly when i < quota, for i = 0..BITSTREAM-1. P therefore holds quota ones.
REQ-022 Index arithmetic is resolved at elaboration. Modulo wraps at BITSTREAM with no truncation error.
REQ-023 out_valid is high throughout STREAM. The first beat is valid on the cycle after the grant (latency 1).
REQ-024 Beat k (k = 0..BITSTREAM-1) presents out_bit = P[k], LSB first. The beat counter advances only on out_valid && out_ready.
REQ-025 out_bit and out_id hold stable while out_valid && !out_ready.
REQ-026 out_last is high exactly when the beat counter equals BITSTREAM-1.
REQ-027 After the last handshake the block spends one IDLE cycle before the next grant (one-bubble turnaround).
REQ-028 flush in STREAM: return to IDLE on the next edge, clear the counter, emit no out_last; flush has priority over a simultaneous handshake.
REQ-029 flush in IDLE: ignored; the grant proceeds.
REQ-030 A requester deasserting req_valid in STREAM has no effect on the stream in progress.

Reset
REQ-031 rst_n low asynchronously forces: IDLE, rr_ptr=0, beat counter=0, P=0, out_id=0, out_valid=0, out_last=0, busy=0, req_ready=0.
REQ-032 Reset asserted mid-stream abandons the stream. The first grant after release goes to the lowest asserted index at or above 0.

Configuration
REQ-033 Macro WEYL_SCHED_ONES_CNT_EN defined: add output ones_cnt, width clog2(BITSTREAM)+1. It counts handshaken beats with out_bit=1, clears on grant/flush/reset, and holds after out_last.
REQ-034 Macro undefined: port ones_cnt and its logic are absent; all other behaviour is identical.

Structure
REQ-035 Package weyl_pkg holds FSM state enum (ST_IDLE, ST_STREAM), default BITSTREAM/BASE/STRIDE constants, and a constant function for the Weyl index.
REQ-036 Sub-module weyl_rr_arb (NREQ-wide round-robin arbiter, combinational grant, registered pointer) is instantiated once; the FSM and pattern shifter stay in weyl_sched.

Verification
REQ-037 Single request, quota=1, out_ready=1: grant cycle 0; beats 0..63 start at cycle 1; out_bit=1 only at beat 61; out_last at beat 63.
REQ-038 quota=2: ones at beats 61 and 14 only. quota=0: all 64 beats are 0. quota=63: exactly one zero beat, at (61+63*17) mod 64 = 44.
REQ-039 All four requesters valid continuously: grants go 0,1,2,3,0. Each stream is 64 beats followed by a 1-cycle gap; out_id matches the grant.
REQ-040 out_ready toggled pseudo-randomly: the beat sequence is unchanged, out_bit is stable while stalled, and the total is still 64 handshakes.
REQ-041 flush at beat 20 together with a handshake: next cycle IDLE, no out_last; the next grant follows rr order. rst_n pulsed at beat 30: all outputs go to 0 immediately.
REQ-042 WEYL_SCHED_ONES_CNT_EN defined, quota=37: ones_cnt=37 after out_last, and it clears to 0 on the next grant.

Source files
------------

// File: rtl/weyl_pkg.sv
// Shared types and constants for the Weyl-sequence stream scheduler.
// The Weyl index helper is evaluated only with constant arguments, so it folds away at elaboration.
package weyl_pkg;

  localparam int unsigned WEYL_BITSTREAM = 64;
  localparam int unsigned WEYL_BASE      = 61;
  localparam int unsigned WEYL_STRIDE    = 17;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } weyl_state_e;

  function automatic int unsigned weyl_idx(input int unsigned base,
                                           input int unsigned stride,
                                           input int unsigned bs,
                                           input int unsigned i);
    return (base + i * stride) % bs;
  endfunction

endpackage

// File: rtl/weyl_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searched from a registered pointer.
// The pointer moves to one past the winner whenever the grant is accepted.
module weyl_rr_arb #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  logic [IDW-1:0] rr_ptr;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      int unsigned idx;
      idx = (32'(rr_ptr) + off) % NREQ;
      if (!gnt_any && req[IDW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
    gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept && gnt_any) begin
      rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/weyl_sched.sv
// Weyl-sequence bitstream scheduler: grants one requester, then streams a BITSTREAM-beat
// pattern holding `quota` ones. Optional ones counter output under WEYL_SCHED_ONES_CNT_EN.
module weyl_sched
  import weyl_pkg::*;
#(
  parameter  int unsigned BITSTREAM = WEYL_BITSTREAM,
  parameter  int unsigned BASE      = WEYL_BASE,
  parameter  int unsigned STRIDE    = WEYL_STRIDE,
  parameter  int unsigned NREQ      = 4,
  localparam int unsigned IW        = $clog2(BITSTREAM),
  localparam int unsigned IDW       = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*IW-1:0] req_quota,
  output logic [NREQ-1:0]    req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_bit,
  output logic [IDW-1:0]     out_id,
  output logic               out_last,
  output logic               busy
`ifdef WEYL_SCHED_ONES_CNT_EN
  ,
  output logic [IW:0]        ones_cnt
`endif
);

  weyl_state_e          state;
  logic [BITSTREAM-1:0] shreg;
  logic [IW-1:0]        beat_cnt;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_idx;
  logic                 gnt_any;
  logic [IW-1:0]        quota_sel;
  logic [BITSTREAM-1:0] pat;
  logic                 hs;

  weyl_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .accept (state == ST_IDLE),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_any(gnt_any)
  );

  // Gated by rst_n so the grant is invisible while reset is held.
  assign req_ready = (state == ST_IDLE && rst_n) ? gnt : '0;
  assign busy      = (state == ST_STREAM);
  assign out_bit   = shreg[0];
  assign hs        = out_valid && out_ready;

  always_comb begin
    quota_sel = '0;
    for (int unsigned n = 0; n < NREQ; n++) begin
      if (gnt_idx == IDW'(n)) quota_sel = req_quota[n*IW +: IW];
    end
  end

  // The i-th Weyl position is one when i < quota; positions are constants per bit.
  always_comb begin
    pat = '0;
    for (int unsigned i = 0; i < BITSTREAM; i++) begin
      pat[IW'(weyl_idx(BASE, STRIDE, BITSTREAM, i))] = (i < 32'(quota_sel));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      beat_cnt  <= '0;
      out_id    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            state     <= ST_STREAM;
            shreg     <= pat;
            out_id    <= gnt_idx;
            beat_cnt  <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (flush) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (hs) begin
            if (out_last) begin
              state     <= ST_IDLE;
              beat_cnt  <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              shreg    <= shreg >> 1;
              out_last <= (beat_cnt == IW'(BITSTREAM - 2));
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef WEYL_SCHED_ONES_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt <= '0;
    end else if (state == ST_IDLE && gnt_any) begin
      ones_cnt <= '0;
    end else if (state == ST_STREAM && flush) begin
      ones_cnt <= '0;
    end else if (state == ST_STREAM && hs && shreg[0]) begin
      ones_cnt <= ones_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_weyl_sched.sv
// Self-checking bench for weyl_sched: random quotas and backpressure against a spec-level model.
module tb_weyl_sched;

  localparam int unsigned BS     = 64;
  localparam int unsigned BASE   = 61;
  localparam int unsigned STRIDE = 17;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned IW     = 6;
  localparam int unsigned IDW    = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*IW-1:0] req_quota = '0;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               out_bit;
  logic [IDW-1:0]     out_id;
  logic               out_last;
  logic               busy;
`ifdef WEYL_SCHED_ONES_CNT_EN
  logic [IW:0]        ones_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int model_ptr = 0;

  weyl_sched #(
    .BITSTREAM(BS),
    .BASE     (BASE),
    .STRIDE   (STRIDE),
    .NREQ     (NREQ)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .req_valid(req_valid),
    .req_quota(req_quota),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bit  (out_bit),
    .out_id   (out_id),
    .out_last (out_last),
    .busy     (busy)
`ifdef WEYL_SCHED_ONES_CNT_EN
    ,
    .ones_cnt (ones_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Beat k carries a one when the Weyl step i landing on k satisfies i < quota.
  function automatic logic model_bit(input int k, input int q);
    for (int i = 0; i < int'(BS); i++)
      if ((int'(BASE) + i * int'(STRIDE)) % int'(BS) == k) return (i < q);
    return 1'b0;
  endfunction

  function automatic int model_winner(input logic [NREQ-1:0] v);
    for (int off = 0; off < int'(NREQ); off++)
      if (v[(model_ptr + off) % int'(NREQ)]) return (model_ptr + off) % int'(NREQ);
    return -1;
  endfunction

  task automatic set_quota(input int n, input int q);
    req_quota[n*IW +: IW] = IW'(q);
  endtask

  // Called at a negedge in IDLE with req_valid/req_quota already driven.
  task automatic serve(input int ready_pct, input int flush_beat, input int rst_beat,
                       input bit drop_valid);
    int   w, q, k, ones;
    logic rdy;
    bit   fl;
    #1;
    w = model_winner(req_valid);
    if (w < 0) begin
      check("winner_exists", 0, 1);
      return;
    end
    check("req_ready", 64'(req_ready), 64'(1) << w);
    check("busy_idle", busy, 0);
    q = int'(req_quota[w*IW +: IW]);
    model_ptr = (w + 1) % int'(NREQ);
    @(negedge clk);
    if (drop_valid) req_valid = '0;
    k = 0;
    ones = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      check("out_valid", out_valid, 1);
      check("busy", busy, 1);
      check("out_id", out_id, w);
      check("out_bit", out_bit, model_bit(k, q));
      check("out_last", out_last, k == int'(BS) - 1);
      check("ready_stream", req_ready, 0);
`ifdef WEYL_SCHED_ONES_CNT_EN
      check("ones_cnt", ones_cnt, ones);
`endif
      if (k == rst_beat) begin
        req_valid = '1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_bit", out_bit, 0);
        check("rst_id", out_id, 0);
        check("rst_ready", req_ready, 0);
        model_ptr = 0;
        @(negedge clk);
        check("rst_hold_valid", out_valid, 0);
        rst_n = 1'b1;
        return;
      end
      rdy = ($urandom_range(99) < ready_pct);
      fl = (k == flush_beat);
      if (fl) rdy = 1'b1;
      out_ready = rdy;
      flush = fl;
      if (rdy && !fl && model_bit(k, q)) ones++;
      @(negedge clk);
      flush = 1'b0;
      if (fl) begin
        check("flush_valid", out_valid, 0);
        check("flush_last", out_last, 0);
        check("flush_busy", busy, 0);
`ifdef WEYL_SCHED_ONES_CNT_EN
        check("flush_ones", ones_cnt, 0);
`endif
        out_ready = 1'b0;
        return;
      end
      if (rdy) begin
        k++;
        if (k == int'(BS)) begin
          check("gap_valid", out_valid, 0);
          check("gap_busy", busy, 0);
          check("gap_last", out_last, 0);
          check("total_ones", ones, q);
`ifdef WEYL_SCHED_ONES_CNT_EN
          check("ones_hold", ones_cnt, q);
`endif
          out_ready = 1'b0;
          return;
        end
      end
    end
    check("stream_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_valid", out_valid, 0);
    check("reset_last", out_last, 0);
    check("reset_busy", busy, 0);
    check("reset_id", out_id, 0);
    check("reset_bit", out_bit, 0);
    check("reset_ready", req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed quota corner cases, one requester at a time.
    set_quota(0, 1);  req_valid = 4'b0001; serve(100, -1, -1, 1'b1);
    set_quota(2, 2);  req_valid = 4'b0100; serve(100, -1, -1, 1'b1);
    set_quota(1, 0);  req_valid = 4'b0010; serve(100, -1, -1, 1'b1);
    set_quota(3, 63); req_valid = 4'b1000; serve(100, -1, -1, 1'b1);
    @(negedge clk);

    // Continuous contention: back-to-back streams with one-cycle gaps.
    for (int n = 0; n < int'(NREQ); n++) set_quota(n, int'($urandom_range(63)));
    req_valid = 4'b1111;
    repeat (5) serve(100, -1, -1, 1'b0);

    // Random backpressure.
    repeat (3) begin
      for (int n = 0; n < int'(NREQ); n++) set_quota(n, int'($urandom_range(63)));
      serve(55, -1, -1, 1'b0);
    end

    // Flush at beat 20 together with a handshake, then rr continues.
    set_quota(2, 37);
    serve(100, 20, -1, 1'b0);
    serve(100, -1, -1, 1'b0);
    serve(100, -1, -1, 1'b0);

    // Reset mid-stream, then first grant to lowest asserted index.
    serve(100, -1, 30, 1'b0);
    set_quota(1, int'($urandom_range(63)));
    req_valid = 4'b0110;
    serve(70, -1, -1, 1'b1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
